// File: rtl/bist_sequencer.sv
// Runtime-programmable BIST controller: INIT, M passes of N run cycles with a GAP
// between passes, FINISH, then DONE. The response is compacted into a MISR and checked against golden.
module bist_sequencer #(
    parameter int               CNT_W = 8,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_cfg,
    input  logic [CNT_W-1:0] m_cfg,
    input  logic [SIG_W-1:0] resp_data,
    input  logic [SIG_W-1:0] golden,
    output logic             mode,
    output logic             init,
    output logic             running,
    output logic             finish,
    output logic             bist_end,
    output logic             pass,
    output logic             fail,
    output logic             aborted,
    output logic [CNT_W-1:0] pass_idx,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_GAP,
        S_FINISH,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] m_lat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [SIG_W-1:0] misr;
    logic [SIG_W-1:0] misr_next;
    logic             pass_r;
    logic             fail_r;
    logic             aborted_r;
    logic             abort_ok;

    always_comb begin
        misr_next = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ resp_data;
    end

    assign abort_ok = abort && (state == S_INIT || state == S_RUN || state == S_GAP);

    // Counters only ever reach the latched limit minus one, so equality compares cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            n_lat     <= '0;
            m_lat     <= '0;
            cyc_cnt   <= '0;
            pass_cnt  <= '0;
            misr      <= '0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else if (abort_ok) begin
            state     <= S_DONE;
            pass_r    <= 1'b0;
            fail_r    <= 1'b1;
            aborted_r <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bist_start) begin
                        n_lat     <= (n_cfg == '0) ? ONE : n_cfg;
                        m_lat     <= (m_cfg == '0) ? ONE : m_cfg;
                        pass_r    <= 1'b0;
                        fail_r    <= 1'b0;
                        aborted_r <= 1'b0;
                        state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    misr     <= SEED;
                    cyc_cnt  <= '0;
                    pass_cnt <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    misr <= misr_next;
                    if (cyc_cnt == n_lat - ONE) begin
                        cyc_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        cyc_cnt <= cyc_cnt + ONE;
                    end
                end
                S_GAP: begin
                    if (pass_cnt == m_lat - ONE) begin
                        state <= S_FINISH;
                    end else begin
                        pass_cnt <= pass_cnt + ONE;
                        state    <= S_RUN;
                    end
                end
                S_FINISH: begin
                    pass_r <= (misr == golden);
                    fail_r <= (misr != golden);
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mode      = (state == S_RUN);
    assign init      = (state == S_INIT);
    assign running   = (state == S_RUN) || (state == S_GAP);
    assign finish    = (state == S_FINISH);
    assign bist_end  = (state == S_DONE);
    assign pass      = pass_r;
    assign fail      = fail_r;
    assign aborted   = aborted_r;
    assign pass_idx  = pass_cnt;
    assign signature = misr;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed testbench for bist_sequencer: sequencing latency, MISR signature,
// verdict, abort, restart from DONE and mid-run reset.
module tb_bist_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        bist_start;
    logic        abort;
    logic [7:0]  n_cfg;
    logic [7:0]  m_cfg;
    logic [15:0] resp_data;
    logic [15:0] golden;
    logic        mode, init, running, finish, bist_end, pass, fail, aborted;
    logic [7:0]  pass_idx;
    logic [15:0] signature;

    int passed = 0;
    int total  = 0;

    int          end_cyc;
    logic [63:0] mode_mask;
    logic [63:0] init_mask;

    bist_sequencer #(
        .CNT_W(8),
        .SIG_W(16),
        .POLY (16'h1021),
        .SEED (16'h0001)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bist_start(bist_start),
        .abort     (abort),
        .n_cfg     (n_cfg),
        .m_cfg     (m_cfg),
        .resp_data (resp_data),
        .golden    (golden),
        .mode      (mode),
        .init      (init),
        .running   (running),
        .finish    (finish),
        .bist_end  (bist_end),
        .pass      (pass),
        .fail      (fail),
        .aborted   (aborted),
        .pass_idx  (pass_idx),
        .signature (signature)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulses start with config n/m, then swaps the config inputs to junk so latching is exercised.
    task automatic start_and_run(input logic [7:0] n, input logic [7:0] m, input logic [7:0] n_mid,
                                 output int ec, output logic [63:0] mm, output logic [63:0] im);
        n_cfg      = n;
        m_cfg      = m;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        n_cfg      = n_mid;
        m_cfg      = 8'd9;
        mm         = '0;
        im         = '0;
        mm[0]      = mode;
        im[0]      = init;
        ec         = -1;
        for (int i = 1; i < 60; i++) begin
            step();
            mm[i] = mode;
            im[i] = init;
            if (bist_end) begin
                ec = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if ({mode, init, running, finish, bist_end, pass, fail, aborted} !== 8'h00)
            $display("[TB] FAIL reset_flags: got %b want 00000000", {mode, init, running, finish, bist_end, pass, fail, aborted});
        else passed++;
        total++;
        if ({pass_idx, signature} !== 24'h0)
            $display("[TB] FAIL reset_regs: got pass_idx=%0d sig=%h want 0/0000", pass_idx, signature);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_pass();
        resp_data = 16'h0000;
        golden    = 16'h0040;
        start_and_run(8'd3, 8'd2, 8'd3, end_cyc, mode_mask, init_mask);
        total++;
        if (end_cyc !== 10) $display("[TB] FAIL pass_latency: got %0d want 10", end_cyc); else passed++;
        total++;
        if (mode_mask !== 64'hEE) $display("[TB] FAIL pass_mode_bursts: got %h want ee", mode_mask); else passed++;
        total++;
        if (init_mask !== 64'h1) $display("[TB] FAIL pass_init: got %h want 1", init_mask); else passed++;
        total++;
        if (signature !== 16'h0040) $display("[TB] FAIL pass_signature: got %h want 0040", signature); else passed++;
        total++;
        if ({pass, fail, aborted, running} !== 4'b1000)
            $display("[TB] FAIL pass_verdict: got %b want 1000", {pass, fail, aborted, running});
        else passed++;
        total++;
        if (pass_idx !== 8'd1) $display("[TB] FAIL pass_idx_final: got %0d want 1", pass_idx); else passed++;
        step();
        total++;
        if ({bist_end, signature} !== {1'b1, 16'h0040})
            $display("[TB] FAIL done_hold: got end=%b sig=%h want 1/0040", bist_end, signature);
        else passed++;
    endtask

    task automatic test_restart_from_done();
        n_cfg      = 8'd2;
        m_cfg      = 8'd1;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        total++;
        if ({init, bist_end, pass, fail} !== 4'b1000)
            $display("[TB] FAIL restart_init: got %b want 1000", {init, bist_end, pass, fail});
        else passed++;
        n_cfg    = 8'd7;
        end_cyc  = -1;
        for (int i = 1; i < 60; i++) begin
            step();
            if (bist_end) begin
                end_cyc = i;
                break;
            end
        end
        total++;
        if (end_cyc !== 5) $display("[TB] FAIL restart_latency: got %0d want 5", end_cyc); else passed++;
        total++;
        if ({signature, pass, fail} !== {16'h0004, 2'b01})
            $display("[TB] FAIL restart_verdict: got sig=%h p=%b f=%b want 0004/0/1", signature, pass, fail);
        else passed++;
    endtask

    task automatic test_fail();
        golden = 16'h0041;
        start_and_run(8'd3, 8'd2, 8'd3, end_cyc, mode_mask, init_mask);
        total++;
        if (end_cyc !== 10) $display("[TB] FAIL fail_latency: got %0d want 10", end_cyc); else passed++;
        total++;
        if ({pass, fail, aborted} !== 3'b010)
            $display("[TB] FAIL fail_verdict: got %b want 010", {pass, fail, aborted});
        else passed++;
    endtask

    task automatic test_zero_config();
        start_and_run(8'd0, 8'd0, 8'd0, end_cyc, mode_mask, init_mask);
        total++;
        if (end_cyc !== 4) $display("[TB] FAIL zero_latency: got %0d want 4", end_cyc); else passed++;
        total++;
        if (mode_mask !== 64'h2) $display("[TB] FAIL zero_mode: got %h want 2", mode_mask); else passed++;
        total++;
        if (signature !== 16'h0002) $display("[TB] FAIL zero_signature: got %h want 0002", signature); else passed++;
    endtask

    // Constant all-ones response drives the feedback path; hand-computed result is 50b0.
    task automatic test_misr_feedback();
        resp_data = 16'hFFFF;
        golden    = 16'h50B0;
        start_and_run(8'd4, 8'd1, 8'd4, end_cyc, mode_mask, init_mask);
        total++;
        if (end_cyc !== 7) $display("[TB] FAIL misr_latency: got %0d want 7", end_cyc); else passed++;
        total++;
        if (mode_mask !== 64'h1E) $display("[TB] FAIL misr_mode: got %h want 1e", mode_mask); else passed++;
        total++;
        if ({signature, pass, fail} !== {16'h50B0, 2'b10})
            $display("[TB] FAIL misr_signature: got sig=%h p=%b f=%b want 50b0/1/0", signature, pass, fail);
        else passed++;
        resp_data = 16'h0000;
    endtask

    task automatic test_abort();
        n_cfg      = 8'd5;
        m_cfg      = 8'd3;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        total++;
        if ({mode, running, pass_idx} !== {2'b11, 8'd1})
            $display("[TB] FAIL abort_pre: got mode=%b run=%b idx=%0d want 1/1/1", mode, running, pass_idx);
        else passed++;
        abort = 1'b1;
        step();
        total++;
        if ({bist_end, mode, pass, fail, aborted} !== 5'b10011)
            $display("[TB] FAIL abort_flags: got %b want 10011", {bist_end, mode, pass, fail, aborted});
        else passed++;
        total++;
        if ({pass_idx, signature} !== {8'd1, 16'h0080})
            $display("[TB] FAIL abort_frozen: got idx=%0d sig=%h want 1/0080", pass_idx, signature);
        else passed++;
        step();
        abort = 1'b0;
        total++;
        if ({bist_end, aborted, signature} !== {2'b11, 16'h0080})
            $display("[TB] FAIL abort_in_done: got end=%b ab=%b sig=%h want 1/1/0080", bist_end, aborted, signature);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        golden = 16'h0040;
        n_cfg      = 8'd3;
        m_cfg      = 8'd2;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        total++;
        if ({mode, pass_idx} !== {1'b1, 8'd1})
            $display("[TB] FAIL midrun_pre: got mode=%b idx=%0d want 1/1", mode, pass_idx);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({mode, init, running, finish, bist_end, pass, fail, aborted, pass_idx, signature} !== 32'h0)
            $display("[TB] FAIL midrun_reset: got flags=%b idx=%0d sig=%h want all 0",
                     {mode, init, running, finish, bist_end, pass, fail, aborted}, pass_idx, signature);
        else passed++;
        step();
        total++;
        if ({init, running, bist_end} !== 3'b000)
            $display("[TB] FAIL midrun_idle: got %b want 000", {init, running, bist_end});
        else passed++;
        start_and_run(8'd3, 8'd2, 8'd3, end_cyc, mode_mask, init_mask);
        total++;
        if ({end_cyc, mode_mask[15:0]} !== {32'd10, 16'h00EE})
            $display("[TB] FAIL midrun_rerun: got end=%0d mode=%h want 10/ee", end_cyc, mode_mask[15:0]);
        else passed++;
        total++;
        if ({signature, pass, fail} !== {16'h0040, 2'b10})
            $display("[TB] FAIL midrun_rerun_verdict: got sig=%h p=%b f=%b want 0040/1/0", signature, pass, fail);
        else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        bist_start = 1'b0;
        abort      = 1'b0;
        n_cfg      = 8'd0;
        m_cfg      = 8'd0;
        resp_data  = 16'h0000;
        golden     = 16'h0000;
        test_reset();
        test_pass();
        test_restart_from_done();
        test_fail();
        test_zero_config();
        test_misr_feedback();
        test_abort();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
